// File: rtl/datapath_mc_if.sv
// datapath_mc control/memory bus.
// Controller drives master; datapath is slave.
interface datapath_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             PCWrite;
  logic             AdrSrc;
  logic             IRWrite;
  logic [1:0]       RegSrc;
  logic             RegWrite;
  logic [1:0]       ImmSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUControl;
  logic [1:0]       ResultSrc;
  logic             MemReady;
  logic [WIDTH-1:0] ReadData;
  logic [WIDTH-1:0] Adr;
  logic [WIDTH-1:0] WriteData;
  logic [31:0]      Instr;
  logic [WIDTH-1:0] PC;
  logic [3:0]       ALUFlags;

  modport master (
    output PCWrite,
    output AdrSrc,
    output IRWrite,
    output RegSrc,
    output RegWrite,
    output ImmSrc,
    output ALUSrcA,
    output ALUSrcB,
    output ALUControl,
    output ResultSrc,
    output MemReady,
    output ReadData,
    input  Adr,
    input  WriteData,
    input  Instr,
    input  PC,
    input  ALUFlags
  );

  modport slave (
    input  PCWrite,
    input  AdrSrc,
    input  IRWrite,
    input  RegSrc,
    input  RegWrite,
    input  ImmSrc,
    input  ALUSrcA,
    input  ALUSrcB,
    input  ALUControl,
    input  ResultSrc,
    input  MemReady,
    input  ReadData,
    output Adr,
    output WriteData,
    output Instr,
    output PC,
    output ALUFlags
  );
endinterface

// File: rtl/datapath_mc.sv
// Multicycle ARM datapath: shared memory port,
// IR/Data/A/WD/ALUOut staging, one ALU, regfile.
module datapath_mc #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          reset,
  datapath_mc_if.slave bus
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] FOUR =
    WIDTH'(4);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [31:0]      ir_q;
  logic [31:0]      ir_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] wd_q;
  logic [WIDTH-1:0] aluout_q;
  logic [WIDTH-1:0] rf_q [0:14];

  logic             en;
  logic [3:0]       ra1;
  logic [3:0]       ra2;
  logic [3:0]       wa;
  logic             rf_we;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] ext_imm;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic [WIDTH-1:0] result;

  assign en       = bus.MemReady;
  assign pc_plus4 = pc_q + FOUR;

  assign ra1 = bus.RegSrc[0] ? 4'hF
                             : ir_q[19:16];
  assign ra2 = bus.RegSrc[1] ? ir_q[15:12]
                             : ir_q[3:0];
  assign wa  = ir_q[15:12];

  // R15 is not stored; it reads as PC+4 (fetch+8)
  always_comb begin
    rd1 = pc_plus4;
    if (ra1 != 4'hF) begin
      rd1 = rf_q[ra1];
    end
  end

  // second read port, same R15 aliasing
  always_comb begin
    rd2 = pc_plus4;
    if (ra2 != 4'hF) begin
      rd2 = rf_q[ra2];
    end
  end

  // immediate extension from IR
  always_comb begin
    ext_imm = '0;
    unique case (bus.ImmSrc)
      2'b00: ext_imm = WIDTH'(ir_q[7:0]);
      2'b01: ext_imm = WIDTH'(ir_q[11:0]);
      2'b10: ext_imm = {
               {(WIDTH-26){ir_q[23]}},
               ir_q[23:0],
               2'b00
             };
      2'b11: ext_imm = '0;
      default: ext_imm = '0;
    endcase
  end

  // ALU operand A select
  always_comb begin
    src_a = '0;
    unique case (bus.ALUSrcA)
      2'b00: src_a = a_q;
      2'b01: src_a = pc_q;
      2'b10: src_a = aluout_q;
      2'b11: src_a = '0;
      default: src_a = '0;
    endcase
  end

  // ALU operand B select
  always_comb begin
    src_b = '0;
    unique case (bus.ALUSrcB)
      2'b00: src_b = wd_q;
      2'b01: src_b = ext_imm;
      2'b10: src_b = FOUR;
      2'b11: src_b = '0;
      default: src_b = '0;
    endcase
  end

  // ALU with NZCV; sub uses a + ~b + 1
  always_comb begin
    sum     = '0;
    alu_res = '0;
    flag_c  = 1'b0;
    flag_v  = 1'b0;
    unique case (bus.ALUControl)
      2'b00: begin
        sum     = {1'b0, src_a}
                + {1'b0, src_b};
        alu_res = sum[WIDTH-1:0];
        flag_c  = sum[WIDTH];
        flag_v  = (src_a[MSB] == src_b[MSB])
                & (alu_res[MSB] != src_a[MSB]);
      end
      2'b01: begin
        sum     = {1'b0, src_a}
                + {1'b0, ~src_b}
                + (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        flag_c  = sum[WIDTH];
        flag_v  = (src_a[MSB] != src_b[MSB])
                & (alu_res[MSB] != src_a[MSB]);
      end
      2'b10: alu_res = src_a & src_b;
      2'b11: alu_res = src_a | src_b;
      default: alu_res = '0;
    endcase
    flag_n = alu_res[MSB];
    flag_z = (alu_res == '0);
  end

  // writeback/PC source select
  always_comb begin
    result = '0;
    unique case (bus.ResultSrc)
      2'b00: result = aluout_q;
      2'b01: result = data_q;
      2'b10: result = alu_res;
      2'b11: result = aluout_q;
      default: result = '0;
    endcase
  end

  assign pc_d  = bus.PCWrite ? result : pc_q;
  assign ir_d  = bus.IRWrite ? bus.ReadData[31:0]
                             : ir_q;
  assign rf_we = en & bus.RegWrite
               & (wa != 4'hF);

  // architectural and staging registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      data_q   <= '0;
      a_q      <= '0;
      wd_q     <= '0;
      aluout_q <= '0;
    end else if (en) begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      data_q   <= bus.ReadData;
      a_q      <= rd1;
      wd_q     <= rd2;
      aluout_q <= alu_res;
    end
  end

  // register file R0-R14, no bypass
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 15; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we) begin
      rf_q[wa] <= result;
    end
  end

  assign bus.Adr       = bus.AdrSrc ? result
                                    : pc_q;
  assign bus.WriteData = wd_q;
  assign bus.Instr     = ir_q;
  assign bus.PC        = pc_q;
  assign bus.ALUFlags  = {flag_n, flag_z,
                          flag_c, flag_v};

endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc: reset, fetch,
// R15, ADD, stall, flags, LDR, branch.
module tb_datapath_mc;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  datapath_mc_if #(.WIDTH(32)) bus ();

  datapath_mc #(
    .WIDTH    (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic ctl(
    input logic       pcw,
    input logic       adrs,
    input logic       irw,
    input logic [1:0] rsrc,
    input logic       rw,
    input logic [1:0] imm,
    input logic [1:0] sa,
    input logic [1:0] sb,
    input logic [1:0] op,
    input logic [1:0] res
  );
    bus.PCWrite    = pcw;
    bus.AdrSrc     = adrs;
    bus.IRWrite    = irw;
    bus.RegSrc     = rsrc;
    bus.RegWrite   = rw;
    bus.ImmSrc     = imm;
    bus.ALUSrcA    = sa;
    bus.ALUSrcB    = sb;
    bus.ALUControl = op;
    bus.ResultSrc  = res;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic c_idle();
    ctl(0, 0, 0, 2'b00, 0, 2'b00,
        2'b00, 2'b00, 2'b00, 2'b00);
  endtask

  task automatic c_fetch();
    ctl(1, 0, 1, 2'b00, 0, 2'b00,
        2'b01, 2'b10, 2'b00, 2'b10);
  endtask

  task automatic c_decode(input logic [1:0] rs);
    ctl(0, 0, 0, rs, 0, 2'b00,
        2'b01, 2'b10, 2'b00, 2'b10);
  endtask

  // Adr shows register A through a zero-add
  task automatic probe_a();
    ctl(0, 1, 0, 2'b00, 0, 2'b00,
        2'b00, 2'b11, 2'b00, 2'b10);
    #1;
  endtask

  // Adr shows ALUOut
  task automatic probe_aluout();
    ctl(0, 1, 0, 2'b00, 0, 2'b00,
        2'b11, 2'b11, 2'b00, 2'b00);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    bus.MemReady = 1'b1;
    bus.ReadData = '0;
    c_idle();
    #1;
    chk("rst_pc", bus.PC, 32'h0);
    chk("rst_instr", bus.Instr, 32'h0);
    chk("rst_adr", bus.Adr, 32'h0);
    chk("rst_wd", bus.WriteData, 32'h0);
    #1 reset = 1'b1;

    // ADD R1,R0,#3 at PC 0
    bus.ReadData = 32'hE2801003;
    c_fetch();
    tick();
    chk("fetch_instr", bus.Instr, 32'hE2801003);
    chk("fetch_pc", bus.PC, 32'h4);

    c_decode(2'b01);
    tick();
    probe_a();
    chk("r15_read", bus.Adr, 32'h8);

    c_decode(2'b00);
    tick();
    ctl(0, 0, 0, 2'b00, 0, 2'b00,
        2'b00, 2'b01, 2'b00, 2'b10);
    tick();
    ctl(0, 0, 0, 2'b00, 1, 2'b00,
        2'b00, 2'b11, 2'b00, 2'b00);
    tick();

    // ADD R1,R1,#5 at PC 4
    bus.ReadData = 32'hE2811005;
    c_fetch();
    tick();
    chk("fetch2_pc", bus.PC, 32'h8);
    c_decode(2'b00);
    tick();
    ctl(0, 1, 0, 2'b00, 0, 2'b00,
        2'b00, 2'b01, 2'b00, 2'b10);
    #1;
    chk("add_flags", 32'(bus.ALUFlags), 32'h0);
    chk("add_res", bus.Adr, 32'h8);
    tick();
    ctl(0, 0, 0, 2'b00, 1, 2'b00,
        2'b00, 2'b11, 2'b00, 2'b00);
    tick();
    c_decode(2'b00);
    tick();
    probe_a();
    chk("r1_eq8", bus.Adr, 32'h8);

    // fetch stalled for 3 cycles; ALUOut = 12
    bus.ReadData = 32'hE2512005;
    bus.MemReady = 1'b0;
    c_fetch();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", bus.PC, 32'h8);
      chk("stall_ir", bus.Instr, 32'hE2811005);
    end
    probe_aluout();
    chk("stall_aluout", bus.Adr, 32'hC);
    c_fetch();
    bus.MemReady = 1'b1;
    tick();
    chk("unstall_ir", bus.Instr, 32'hE2512005);
    chk("unstall_pc", bus.PC, 32'hC);

    // 5 - 5
    ctl(0, 0, 0, 2'b00, 0, 2'b00,
        2'b11, 2'b01, 2'b00, 2'b10);
    tick();
    ctl(0, 0, 0, 2'b00, 0, 2'b00,
        2'b10, 2'b01, 2'b01, 2'b10);
    #1;
    chk("sub_flags", 32'(bus.ALUFlags), 32'h6);

    // LDR R2,[R0,#1] at PC 12
    bus.ReadData = 32'hE5902001;
    c_fetch();
    tick();
    c_decode(2'b00);
    tick();
    ctl(0, 0, 0, 2'b00, 0, 2'b01,
        2'b00, 2'b01, 2'b00, 2'b10);
    tick();
    ctl(0, 1, 0, 2'b00, 0, 2'b00,
        2'b00, 2'b00, 2'b00, 2'b00);
    bus.ReadData = 32'h7FFFFFFF;
    #1;
    chk("ldr_adr", bus.Adr, 32'h1);
    tick();
    ctl(0, 0, 0, 2'b00, 1, 2'b00,
        2'b00, 2'b00, 2'b00, 2'b01);
    tick();

    // WD = R2, ALUOut = 1
    ctl(0, 0, 0, 2'b10, 0, 2'b00,
        2'b11, 2'b01, 2'b00, 2'b10);
    tick();
    chk("ldr_wd", bus.WriteData, 32'h7FFFFFFF);
    ctl(0, 1, 0, 2'b00, 0, 2'b00,
        2'b10, 2'b00, 2'b00, 2'b10);
    #1;
    chk("ovf_flags", 32'(bus.ALUFlags), 32'h9);
    chk("ovf_res", bus.Adr, 32'h80000000);

    // PC <- 0x20 via Data
    bus.ReadData = 32'h20;
    c_idle();
    tick();
    ctl(1, 0, 0, 2'b00, 0, 2'b00,
        2'b11, 2'b11, 2'b00, 2'b01);
    tick();
    chk("set_pc20", bus.PC, 32'h20);

    // B . (offset -8)
    bus.ReadData = 32'hEAFFFFFE;
    c_fetch();
    tick();
    c_decode(2'b00);
    tick();
    ctl(0, 1, 0, 2'b00, 0, 2'b10,
        2'b11, 2'b01, 2'b00, 2'b10);
    #1;
    chk("br_extimm", bus.Adr, 32'hFFFFFFF8);
    ctl(1, 0, 0, 2'b00, 0, 2'b10,
        2'b10, 2'b01, 2'b00, 2'b10);
    tick();
    chk("br_pc", bus.PC, 32'h20);

    // PC <- 0x40, then async reset mid-cycle
    bus.ReadData = 32'h40;
    c_idle();
    tick();
    ctl(1, 0, 0, 2'b00, 0, 2'b00,
        2'b11, 2'b11, 2'b00, 2'b01);
    tick();
    chk("set_pc40", bus.PC, 32'h40);
    bus.ReadData = 32'hE2811005;
    c_fetch();
    #2 reset = 1'b0;
    #1;
    chk("arst_pc", bus.PC, 32'h0);
    chk("arst_instr", bus.Instr, 32'h0);
    chk("arst_adr", bus.Adr, 32'h0);
    chk("arst_wd", bus.WriteData, 32'h0);
    #1 reset = 1'b1;
    tick();
    chk("post_rst_pc", bus.PC, 32'h4);
    chk("post_rst_ir", bus.Instr, 32'hE2811005);
    c_decode(2'b00);
    tick();
    probe_a();
    chk("rst_r1", bus.Adr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
